// File: rtl/sw_debounce_if.sv
// sw_debounce_if: switch levels in, debounced levels and change pulses out.
interface sw_debounce_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] sw_raw_in;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_changed_out;
  logic             any_changed_out;
  modport master (output sw_raw_in, input sw_out, sw_changed_out, any_changed_out);
  modport slave  (input sw_raw_in, output sw_out, sw_changed_out, any_changed_out);
endinterface

// File: rtl/sw_debounce.sv
// sw_debounce: per-bit synchroniser, stability counter and one-cycle change pulse.
module sw_debounce #(
  parameter int WIDTH         = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16
) (
  input  logic         clk_in,
  input  logic         rst_in,
  sw_debounce_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] sw_q, sw_d, chg_q, chg_d;
  logic             any_q;
  always_comb begin
    chg_d = '0;
    cnt_d = '{default: '0};
    for (int i = 0; i < WIDTH; i++) begin
      chg_d[i] = (sync_q[SYNC_STAGES-1][i] != sw_q[i]) && (cnt_q[i] == CNT_MAX);
      cnt_d[i] = (sync_q[SYNC_STAGES-1][i] == sw_q[i] || chg_d[i]) ? '0 : cnt_q[i] + CW'(1);
    end
  end
  assign sw_d = sw_q ^ chg_d;
  always_ff @(posedge clk_in)
    if (rst_in) begin
      sync_q <= '{default: '0};
      cnt_q  <= '{default: '0};
      sw_q   <= '0;
      chg_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      sync_q[0] <= bus.sw_raw_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      cnt_q <= cnt_d;
      sw_q  <= sw_d;
      chg_q <= chg_d;
      any_q <= |chg_d;
    end
  assign bus.sw_out          = sw_q;
  assign bus.sw_changed_out  = chg_q;
  assign bus.any_changed_out = any_q;
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed scenarios plus randomized bouncing against a sliding-window model.
module tb_sw_debounce;
  localparam int W = 8, SS = 2, SC = 16, N = 8192;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0, fails = 0;
  sw_debounce_if #(.WIDTH(W)) bus();
  sw_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .STABLE_CYCLES(SC)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  // Model: a bit flips at edge e when the synchronised value seen at each of the
  // last SC edges (all after its last flip/reset) differed from the debounced value.
  bit [W-1:0] raw_h [N];
  bit         rst_h [N];
  bit [W-1:0] s_h   [N];
  int         last  [W];
  int         e = 0;
  bit [W-1:0] exp_sw = '0, exp_chg = '0;
  bit         exp_any = 1'b0;
  always @(posedge clk) begin
    bit [W-1:0] sv;
    bit ok;
    e = e + 1;
    raw_h[e] = bus.sw_raw_in;
    rst_h[e] = rst;
    sv = (e - SS + 1 >= 1) ? raw_h[e-SS+1] : '0;
    for (int j = 0; j < SS; j++) if (e - j < 1 || rst_h[e-j]) sv = '0;
    s_h[e] = sv;
    if (rst) begin
      exp_sw = '0;
      exp_chg = '0;
      for (int i = 0; i < W; i++) last[i] = e;
    end else begin
      for (int i = 0; i < W; i++) begin
        ok = (e - SC + 1 > last[i]);
        if (ok) for (int k = 0; k < SC; k++) if (s_h[e-1-k][i] == exp_sw[i]) ok = 1'b0;
        exp_chg[i] = ok;
        if (ok) begin
          exp_sw[i] = ~exp_sw[i];
          last[i] = e;
        end
      end
    end
    exp_any = |exp_chg;
  end
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sw_raw_in = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.sw_raw_in = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.sw_out !== 8'h00 || bus.sw_changed_out !== 8'h00 || bus.any_changed_out !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold got sw=%h chg=%h any=%b exp 00/00/0", bus.sw_out, bus.sw_changed_out, bus.any_changed_out);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (bus.sw_out !== (k >= 18 ? 8'hFF : 8'h00)) begin
        fails++;
        $display("FAIL reset_release edge %0d got sw=%h exp %h", k, bus.sw_out, (k >= 18 ? 8'hFF : 8'h00));
      end
    end
  endtask
  task automatic test_clean_step();
    do_reset();
    bus.sw_raw_in = 8'h05;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      checks++;
      if (bus.sw_out !== (k >= 18 ? 8'h05 : 8'h00) || bus.sw_changed_out !== (k == 18 ? 8'h05 : 8'h00)
          || bus.any_changed_out !== (k == 18)) begin
        fails++;
        $display("FAIL clean_step edge %0d got sw=%h chg=%h any=%b exp %h/%h/%b", k, bus.sw_out,
                 bus.sw_changed_out, bus.any_changed_out, (k >= 18 ? 8'h05 : 8'h00), (k == 18 ? 8'h05 : 8'h00), (k == 18));
      end
    end
  endtask
  task automatic test_bounce();
    int pulses = 0;
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      bus.sw_raw_in = {7'b0, (k <= 12) ? (((k - 1) / 3) % 2 == 0) : 1'b1};
      @(negedge clk);
      pulses += int'(bus.sw_changed_out[0]);
      checks++;
      if (bus.sw_out[0] !== (k >= 30) || bus.sw_changed_out[0] !== (k == 30)) begin
        fails++;
        $display("FAIL bounce edge %0d got sw0=%b chg0=%b exp %b/%b", k, bus.sw_out[0], bus.sw_changed_out[0], (k >= 30), (k == 30));
      end
    end
    checks++;
    if (pulses != 1) begin
      fails++;
      $display("FAIL bounce_pulses got %0d exp 1", pulses);
    end
  endtask
  task automatic test_glitch();
    do_reset();
    bus.sw_raw_in = 8'h80;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      bus.sw_raw_in = 8'h00;
      checks++;
      if (bus.sw_out !== 8'h00 || bus.sw_changed_out !== 8'h00 || bus.any_changed_out !== 1'b0) begin
        fails++;
        $display("FAIL glitch edge %0d got sw=%h chg=%h any=%b exp 00/00/0", k, bus.sw_out, bus.sw_changed_out, bus.any_changed_out);
      end
    end
  endtask
  task automatic test_independent();
    logic [7:0] es, ec;
    do_reset();
    bus.sw_raw_in = 8'h04;
    for (int k = 1; k <= 26; k++) begin
      if (k == 6) bus.sw_raw_in = 8'h0C;
      @(negedge clk);
      es = (k >= 18 ? 8'h04 : 8'h00) | (k >= 23 ? 8'h08 : 8'h00);
      ec = (k == 18 ? 8'h04 : 8'h00) | (k == 23 ? 8'h08 : 8'h00);
      checks++;
      if (bus.sw_out !== es || bus.sw_changed_out !== ec || bus.any_changed_out !== (ec != 0)) begin
        fails++;
        $display("FAIL independent edge %0d got sw=%h chg=%h any=%b exp %h/%h/%b", k, bus.sw_out,
                 bus.sw_changed_out, bus.any_changed_out, es, ec, (ec != 0));
      end
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.sw_raw_in = 8'h02;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.sw_out !== 8'h00 || bus.sw_changed_out !== 8'h00 || bus.any_changed_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_hold got sw=%h chg=%h any=%b exp 00/00/0", bus.sw_out, bus.sw_changed_out, bus.any_changed_out);
    end
    rst = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      checks++;
      if (bus.sw_out !== (k >= 18 ? 8'h02 : 8'h00) || bus.sw_changed_out !== (k == 18 ? 8'h02 : 8'h00)) begin
        fails++;
        $display("FAIL reset_mid edge %0d got sw=%h chg=%h exp %h/%h", k, bus.sw_out, bus.sw_changed_out,
                 (k >= 18 ? 8'h02 : 8'h00), (k == 18 ? 8'h02 : 8'h00));
      end
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++) if ($urandom_range(0, 19) == 0) bus.sw_raw_in[i] = ~bus.sw_raw_in[i];
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
      checks++;
      if (bus.sw_out !== exp_sw || bus.sw_changed_out !== exp_chg || bus.any_changed_out !== exp_any) begin
        fails++;
        $display("FAIL random cycle %0d got sw=%h chg=%h any=%b exp %h/%h/%b", c, bus.sw_out,
                 bus.sw_changed_out, bus.any_changed_out, exp_sw, exp_chg, exp_any);
      end
    end
    rst = 1'b0;
  endtask
  initial begin
    bus.sw_raw_in = '0;
    test_reset();
    test_clean_step();
    test_bounce();
    test_glitch();
    test_independent();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Input-conditioning stage directly upstream of the switch-to-LED register stage; its sw_out drives that stage's sw_in.
- Synchronises asynchronous, bouncing switch inputs into the clk_in domain.
- Debounces each bit independently.
- Emits a one-cycle change pulse per bit whenever a debounced value flips.

Parameters:
- WIDTH, 8, number of switch bits; must match the downstream stage's WIDTH.
- SYNC_STAGES, 2, flops in each bit's synchroniser chain; legal range >= 2.
- STABLE_CYCLES, 16, consecutive cycles a synchronised bit must differ from sw_out before sw_out takes the new value; legal range >= 2.

Ports:
- clk_in  input  1  sole clock.
- rst_in  input  1  reset.
- sw_raw_in  input  WIDTH  raw asynchronous switch levels.
- sw_out  output  WIDTH  debounced switch levels, registered; feeds the downstream sw_in.
- sw_changed_out  output  WIDTH  per-bit one-cycle pulse, high in the cycle sw_out[i] takes a new value.
- any_changed_out  output  1  OR-reduction of sw_changed_out, registered alongside it (same cycle).

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high. rst_in is sampled only on rising clk_in.
- Reset values: all synchroniser flops 0, all counters 0, sw_out 0, sw_changed_out 0, any_changed_out 0.
- Reset mid-operation: rst_in high at an edge clears everything at that edge, overriding any count in progress. No change pulse is generated by reset.
- Synchroniser: per bit, a SYNC_STAGES-deep flop chain. sync[i] denotes the last stage. No logic sits between chain stages.
- Counter: per bit, width $clog2(STABLE_CYCLES). Maximum value held is STABLE_CYCLES-1; the counter never wraps.
- Per-bit rule at each non-reset edge:
  - sync[i] == sw_out[i]: cnt[i] <= 0; sw_changed_out[i] <= 0.
  - sync[i] != sw_out[i] and cnt[i] < STABLE_CYCLES-1: cnt[i] <= cnt[i]+1; sw_changed_out[i] <= 0.
  - sync[i] != sw_out[i] and cnt[i] == STABLE_CYCLES-1: sw_out[i] <= sync[i]; cnt[i] <= 0; sw_changed_out[i] <= 1.
- Effective per-bit state: STABLE (cnt=0, match) and PENDING (mismatch, counting). A single matching cycle while PENDING returns to STABLE with cnt cleared; a glitch restarts the window.
- Latency: raw level change set up before edge 1 appears on sw_out after edge SYNC_STAGES+STABLE_CYCLES. With defaults this is edge 18.
- Pulse width: sw_changed_out[i] is high for exactly one cycle per flip. Back-to-back flips of the same bit are at least STABLE_CYCLES cycles apart.
- Bit independence: bits never share counters. Simultaneous qualifying flips on several bits pulse in the same cycle.
- Data path: no arithmetic beyond the counter increment; the counter cannot overflow by construction.

Test Plan:
- Reset: hold rst_in=1 for 3 cycles with sw_raw_in=8'hFF -> sw_out=8'h00, sw_changed_out=0, any_changed_out=0 throughout; after release, sw_out=8'hFF at edge 18 post-release.
- Clean step: from reset state, sw_raw_in 8'h00->8'h05 before edge 1 -> sw_out=8'h00 through edge 17; sw_out=8'h05 and sw_changed_out=8'h05 at edge 18; sw_changed_out=8'h00 at edge 19.
- Bounce: bit0 toggles 1,0,1,0 every 3 cycles, then holds 1 -> sw_out[0] stays 0 until 18 edges after the final rising transition, then a single pulse on sw_changed_out[0].
- One-cycle glitch on bit 7 (high for 1 cycle, then low) -> sw_out[7] never changes; no pulse.
- Independent bits: bit2 rises at cycle 0, bit3 rises at cycle 5 -> sw_out[2] sets at edge 18 and sw_out[3] at edge 23; separate single-cycle pulses; any_changed_out high only in those two cycles.
- Reset mid-count: bit1 pending with cnt=10, assert rst_in for 1 cycle -> cnt cleared, sw_out=0, no pulse; full 18-edge latency restarts after release.
